// File: rtl/mux8t1_4.sv
// 8-to-1 word selector with combinational output, one-hot select decode and a registered copy.
// Optional: define MUX8T1_4_PARITY_EN to add parity_r, the even parity of the captured word.
module mux8t1_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [WIDTH-1:0] x4,
    input  logic [WIDTH-1:0] x5,
    input  logic [WIDTH-1:0] x6,
    input  logic [WIDTH-1:0] x7,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_r,
    output logic             o_r_valid,
`ifdef MUX8T1_4_PARITY_EN
    output logic             parity_r,
`endif
    output logic [7:0]       sel_oh
);

    logic [7:0][WIDTH-1:0] xs;

    assign xs = {x7, x6, x5, x4, x3, x2, x1, x0};

    // Direct index keeps the select a single mux level; an X on sel propagates to o.
    always_comb begin
        o      = xs[sel];
        sel_oh = 8'b1 << sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_r       <= '0;
            o_r_valid <= 1'b0;
        end else if (en) begin
            o_r       <= o;
            o_r_valid <= 1'b1;
        end
    end

`ifdef MUX8T1_4_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_r <= 1'b0;
        else if (en)
            parity_r <= ^o;
    end
`endif

endmodule

// File: tb/tb_mux8t1_4.sv
// Bench for mux8t1_4: vector table for the combinational path, hand sequences for the
// registered path and async reset, then random traffic against a behavioural model.
module tb_mux8t1_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] sel;
    logic [3:0] x [8];
    logic [3:0] o, o_r;
    logic       o_r_valid;
    logic [7:0] sel_oh;
`ifdef MUX8T1_4_PARITY_EN
    logic       parity_r;
`endif

    mux8t1_4 #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
        .o(o), .o_r(o_r), .o_r_valid(o_r_valid),
`ifdef MUX8T1_4_PARITY_EN
        .parity_r(parity_r),
`endif
        .sel_oh(sel_oh)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] xw;
        logic [2:0]  sel;
        logic [3:0]  eo;
        logic [7:0]  eoh;
    } vec_t;

    vec_t tbl[10];

    // behavioural model state for the registered path
    logic [3:0] m_or;
    logic       m_v;
    logic       m_p;

    task automatic load_word(input logic [31:0] w);
        for (int j = 0; j < 8; j++) x[j] = w[j*4 +: 4];
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 3'd0;
        load_word(32'h76543210);

        for (int k = 0; k < 8; k++) begin
            tbl[k].xw  = 32'h76543210;
            tbl[k].sel = 3'(k);
            tbl[k].eo  = 4'(k);
            tbl[k].eoh = 8'h01 << k;
        end
        tbl[8] = '{xw: 32'h76A43210, sel: 3'd5, eo: 4'hA, eoh: 8'h20};
        tbl[9] = '{xw: 32'hFEDCBA98, sel: 3'd0, eo: 4'h8, eoh: 8'h01};

        #1;
        chk("reset_o_r", 32'(o_r), 32'h0);
        chk("reset_valid", 32'(o_r_valid), 32'h0);
        chk("reset_o_comb", 32'(o), 32'h0);
`ifdef MUX8T1_4_PARITY_EN
        chk("reset_parity", 32'(parity_r), 32'h0);
`endif

        // combinational table: en=0 so only o/sel_oh move
        for (int i = 0; i < 10; i++) begin
            load_word(tbl[i].xw);
            sel = tbl[i].sel;
            #100;
            chk($sformatf("tbl%0d_o", i), 32'(o), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d_oh", i), 32'(sel_oh), 32'(tbl[i].eoh));
        end

        // registered capture and hold
        @(negedge clk);
        rst_n = 1'b1;
        load_word(32'h76543210);
        en  = 1'b1;
        sel = 3'd3;
        @(posedge clk); #1;
        chk("cap3_o_r", 32'(o_r), 32'h3);
        chk("cap3_valid", 32'(o_r_valid), 32'h1);
        @(negedge clk);
        en  = 1'b0;
        sel = 3'd6;
        #1;
        chk("hold_o_comb", 32'(o), 32'h6);
        @(posedge clk); #1;
        chk("hold_o_r", 32'(o_r), 32'h3);
        chk("hold_valid", 32'(o_r_valid), 32'h1);

        @(negedge clk);
        en  = 1'b1;
        sel = 3'd7;
        @(posedge clk); #1;
        chk("cap7_o_r", 32'(o_r), 32'h7);
`ifdef MUX8T1_4_PARITY_EN
        chk("par7", 32'(parity_r), 32'h1);
        @(negedge clk);
        sel = 3'd6;
        @(posedge clk); #1;
        chk("cap6_o_r", 32'(o_r), 32'h6);
        chk("par6", 32'(parity_r), 32'h0);
        @(negedge clk);
        sel = 3'd7;
        @(posedge clk); #1;
`endif

        // async reset between edges
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_o_r", 32'(o_r), 32'h0);
        chk("arst_valid", 32'(o_r_valid), 32'h0);
        chk("arst_o_comb", 32'(o), 32'h7);
        chk("arst_oh", 32'(sel_oh), 32'h80);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle_valid", 32'(o_r_valid), 32'h0);
        @(negedge clk);
        en  = 1'b1;
        sel = 3'd2;
        @(posedge clk); #1;
        chk("recap_o_r", 32'(o_r), 32'h2);
        chk("recap_valid", 32'(o_r_valid), 32'h1);

        // random traffic against the model; start from a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_or = 4'h0;
        m_v  = 1'b0;
        m_p  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) x[j] = 4'($urandom_range(0, 15));
            sel = 3'($urandom_range(0, 7));
            en  = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_o", 32'(o), 32'(x[sel]));
            chk("rnd_oh", 32'(sel_oh), 32'(1) << sel);
            @(posedge clk);
            if (en) begin
                m_or = x[sel];
                m_v  = 1'b1;
                m_p  = ^x[sel];
            end
            #1;
            chk("rnd_o_r", 32'(o_r), 32'(m_or));
            chk("rnd_valid", 32'(o_r_valid), 32'(m_v));
`ifdef MUX8T1_4_PARITY_EN
            chk("rnd_parity", 32'(parity_r), 32'(m_p));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8t1_4.md
Name: mux8t1_4

Overview:
- 8-to-1 selector for 4-bit data words. Used in the datapath wherever one of eight 4-bit sources is steered onto a single bus.
- The primary output `o` is purely combinational, with zero-cycle latency from `sel`/`x*` to `o`.
- A registered copy `o_r` (with valid flag) is provided for timing-critical consumers. The clock and reset serve only this registered path.

Parameters:
- WIDTH, 4, data width of each input word and of both outputs. Valid range 1..32.

Ports:
- clk  input  1  rising-edge clock for the registered path
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable for the registered path
- sel  input  3  source select; 0 selects x0 … 7 selects x7
- x0  input  WIDTH  data source 0
- x1  input  WIDTH  data source 1
- x2  input  WIDTH  data source 2
- x3  input  WIDTH  data source 3
- x4  input  WIDTH  data source 4
- x5  input  WIDTH  data source 5
- x6  input  WIDTH  data source 6
- x7  input  WIDTH  data source 7
- o  output  WIDTH  combinational selected word
- o_r  output  WIDTH  registered selected word
- o_r_valid  output  1  high once o_r holds a captured value
- sel_oh  output  8  combinational one-hot decode of sel (bit k high when sel==k)

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Combinational output: o = x[sel] at all times.
  - No latch is inferred.
  - o is independent of clk and rst_n; reset does not force o.
- One-hot decode: sel_oh = 1 << sel.
  - Exactly one bit is high for every 3-bit sel value.
  - Combinational; unaffected by reset.
- Registered path:
  - While rst_n=0, asynchronously: o_r=0, o_r_valid=0.
  - On a rising clk edge with rst_n=1 and en=1: o_r <= x[sel] and o_r_valid <= 1.
  - On a rising clk edge with en=0: o_r and o_r_valid hold.
  - Latency from sel/x to o_r is 1 cycle.
- Reset mid-operation: asserting rst_n clears o_r and o_r_valid immediately, without waiting for clk.
  - After release, the first en=1 edge re-captures.
- Release: rst_n deassertion is assumed synchronized externally. No internal synchronizer.
- Simultaneous events: a change of sel or x in the same cycle as en=1 captures the value present at the clk edge (setup-time rules).
- X/Z on sel: o propagates X. No special handling.
- All 8 sel codes are valid. There is no error or out-of-range case.

Optional Feature:
- Macro: MUX8T1_4_PARITY_EN.
- When defined:
  - Adds output port parity_r (1 bit) = even parity (XOR reduction) of the word captured into o_r.
  - Updated under the same en/rst_n rules as o_r; reset value 0.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Sweep: x0..x7 = 0x0..0x7, sel stepped 0→7 every 100 ns -> o equals sel value each step (0x0, 0x1, …, 0x7); sel_oh = 0x01, 0x02, …, 0x80.
- Data change with fixed sel: sel=5, x5 changes 0x5→0xA -> o follows to 0xA with no clock edge required.
- Registered capture: en=1, sel=3, x3=0x3 -> after one clk edge o_r=0x3, o_r_valid=1.
  - Then en=0 and sel=6 -> o_r holds 0x3 while o=0x6.
- Async reset mid-operation: o_r=0x7 and valid, pull rst_n low between edges -> o_r=0 and o_r_valid=0 immediately; o unaffected.
- Parity (MUX8T1_4_PARITY_EN defined): capture x7=0x7 -> parity_r=1; capture x6=0x6 -> parity_r=0.
